// File: rtl/frame_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared state type and default raster timing for the frame scan controller.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 160;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_BLANK  = 45;
    localparam int DEF_POS_W    = 10;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_BLANK;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_BLANK;

endpackage

// File: rtl/pixel_tick_sync.sv
`timescale 1ns/1ps
// Brings the asynchronous pixel clock level into the clk domain and emits
// a single-cycle tick for every rising edge.
module pixel_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic pixel_clk,
    output logic pix_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // NOTE: clocked state uses non-blocking assignments so each flop samples
    // the value its neighbour held before the edge, forming a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= pixel_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pix_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/frame_scan_controller.sv
`timescale 1ns/1ps
// Raster sequencer: walks col/row on synchronized pixel ticks, drives the pixel
// counter's enable/clear and produces sync, blank and frame status.
module frame_scan_controller
    import frame_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int POS_W    = DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pixel_clk,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    output logic             cnt_enable,
    output logic             cnt_s_rst,
    output logic [POS_W-1:0] col,
    output logic [POS_W-1:0] row,
    output logic             active_video,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    localparam logic [POS_W-1:0] H_ACT_P = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT_P = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST  = POS_W'(V_TOTAL - 1);

    state_t           r_state, w_state_next;
    logic [POS_W-1:0] r_col, w_col_next;
    logic [POS_W-1:0] r_row, w_row_next;
    logic             r_stop_pending, w_stop_pending_next;
    logic [15:0]      r_frame_count, w_frame_count_next;
    logic             w_pix_tick;
    logic             w_in_run;
    logic             w_active;

    pixel_tick_sync u_tick_sync (
        .clk       (clk),
        .rst       (rst),
        .pixel_clk (pixel_clk),
        .pix_tick  (w_pix_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_stop_pending <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_col          <= w_col_next;
            r_row          <= w_row_next;
            r_stop_pending <= w_stop_pending_next;
            r_frame_count  <= w_frame_count_next;
        end
    end

    assign w_in_run = (r_state == RUN);
    assign w_active = w_in_run && (r_col < H_ACT_P) && (r_row < V_ACT_P);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next        = r_state;
        w_col_next          = r_col;
        w_row_next          = r_row;
        w_stop_pending_next = r_stop_pending;
        w_frame_count_next  = r_frame_count;
        cnt_enable          = 1'b0;
        cnt_s_rst           = 1'b0;
        frame_done          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !stop) w_state_next = CLEAR;
            end
            CLEAR: begin
                cnt_s_rst           = 1'b1;
                w_col_next          = '0;
                w_row_next          = '0;
                w_stop_pending_next = stop;
                w_state_next        = RUN;
            end
            RUN: begin
                if (stop) w_stop_pending_next = 1'b1;
                if (w_pix_tick) begin
                    // Enable reflects the pixel being left, not the one entered.
                    cnt_enable = w_active;
                    if (r_col == H_LAST) begin
                        if (r_row == V_LAST) begin
                            w_state_next = DONE;
                        end else begin
                            w_col_next = '0;
                            w_row_next = r_row + POS_W'(1);
                        end
                    end else begin
                        w_col_next = r_col + POS_W'(1);
                    end
                end
            end
            DONE: begin
                frame_done         = 1'b1;
                w_frame_count_next = r_frame_count + 16'd1;
                w_col_next         = '0;
                w_row_next         = '0;
                if (stop) w_stop_pending_next = 1'b1;
                // A stop landing in this very cycle still prevents the restart.
                if (continuous && !(r_stop_pending || stop)) w_state_next = CLEAR;
                else                                         w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign col          = r_col;
    assign row          = r_row;
    assign active_video = w_active;
    assign hsync        = w_in_run && (r_col >= H_ACT_P);
    assign vsync        = w_in_run && (r_row >= V_ACT_P);
    assign busy         = (r_state != IDLE);
    assign frame_count  = r_frame_count;

endmodule
